// File: rtl/pc_gen_mw.sv
// pc_gen_mw: instruction fetch address generator.
// It has three states (IDLE, RUN, HELD). It redirects on a flush or a branch,
// and it remembers the target of a branch that arrived while fetch was stalled.
// Optional feature: define PC_ALIGN_CHECK_EN to force redirect targets onto a
// FETCH_BYTES boundary and to pulse misalign_o when a target needed fixing.
module pc_gen_mw #(
    parameter int          ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int          FETCH_BYTES  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_address_i,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              redirect_pending_o,
    output logic              misalign_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HELD = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pending_q, pending_next;
    logic              ce_next;
    logic              misalign_next;

    // Only the fetch-stage stall bit matters here; the later stages are deliberately ignored.
    logic unused_stall;
    assign unused_stall = ^stall[5:1];

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(FETCH_BYTES - 1);

    function automatic logic [ADDR_W-1:0] fix_target(input logic [ADDR_W-1:0] t);
        return t & ~LOW_MASK;
    endfunction

    function automatic logic is_misaligned(input logic [ADDR_W-1:0] t);
        return |(t & LOW_MASK);
    endfunction
`else
    function automatic logic [ADDR_W-1:0] fix_target(input logic [ADDR_W-1:0] t);
        return t;
    endfunction

    function automatic logic is_misaligned(input logic [ADDR_W-1:0] t);
        return (t != t);
    endfunction
`endif

    // Next state and next fetch address. Priority: flush, then stall, then live branch, then pending target, then sequential.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        pending_next  = pending_q;
        misalign_next = 1'b0;
        case (state)
            IDLE: begin
                state_next = RUN;
            end
            RUN, HELD: begin
                if (flush) begin
                    pc_next       = fix_target(new_pc);
                    misalign_next = is_misaligned(new_pc);
                    pending_next  = '0;
                    state_next    = RUN;
                end else if (stall[0]) begin
                    if (branch_flag_i) begin
                        pending_next = branch_target_address_i;
                        state_next   = HELD;
                    end
                end else if (branch_flag_i) begin
                    pc_next       = fix_target(branch_target_address_i);
                    misalign_next = is_misaligned(branch_target_address_i);
                    pending_next  = '0;
                    state_next    = RUN;
                end else if (state == HELD) begin
                    pc_next       = fix_target(pending_q);
                    misalign_next = is_misaligned(pending_q);
                    pending_next  = '0;
                    state_next    = RUN;
                end else begin
                    pc_next = pc + ADDR_W'(FETCH_BYTES);
                end
            end
            default: begin
                state_next   = IDLE;
                pending_next = '0;
            end
        endcase
    end

    // Fetch is enabled in every state except IDLE. It is registered so that ce changes in step with pc.
    assign ce_next = (state_next != IDLE);

    // State registers. Reset discards any pending redirect at once, without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pc         <= RESET_VECTOR;
            pending_q  <= '0;
            ce         <= 1'b0;
            misalign_o <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            pending_q  <= pending_next;
            ce         <= ce_next;
            misalign_o <= misalign_next;
        end
    end

    assign redirect_pending_o = (state == HELD);

endmodule

// File: tb/tb_pc_gen_mw.sv
// tb_pc_gen_mw: self-checking bench for pc_gen_mw.
// It applies a table of directed vectors, a few hand-written reset sequences,
// and random stimulus that is checked against a behavioural model.
module tb_pc_gen_mw;

    localparam int          ADDR_W = 32;
    localparam logic [31:0] RV     = 32'h0000_0100;
    localparam int          FB     = 4;

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [31:0] EXP_1006 = 32'h0000_1004;
    localparam logic [31:0] EXP_NXT  = 32'h0000_1008;
    localparam logic        EXP_MIS  = 1'b1;
`else
    localparam logic [31:0] EXP_1006 = 32'h0000_1006;
    localparam logic [31:0] EXP_NXT  = 32'h0000_100A;
    localparam logic        EXP_MIS  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic [31:0] pc;
    logic        ce;
    logic        redirect_pending_o;
    logic        misalign_o;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: a running flag, the fetch address, and an optional remembered target.
    logic        m_run;
    logic [31:0] m_pc;
    logic        m_pv;
    logic [31:0] m_pend;
    logic        m_mis;

    typedef struct {
        logic        f;
        logic [31:0] npc;
        logic [5:0]  st;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] exp_pc;
        logic        exp_pend;
        logic        exp_mis;
    } vec_t;

    vec_t tbl[$];

    pc_gen_mw #(
        .ADDR_W(ADDR_W),
        .RESET_VECTOR(RV),
        .FETCH_BYTES(FB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .flush(flush),
        .new_pc(new_pc),
        .branch_flag_i(branch_flag_i),
        .branch_target_address_i(branch_target_address_i),
        .pc(pc),
        .ce(ce),
        .redirect_pending_o(redirect_pending_o),
        .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_run  = 1'b0;
        m_pc   = RV;
        m_pv   = 1'b0;
        m_pend = 32'h0;
        m_mis  = 1'b0;
    endtask

    task automatic model_load(input logic [31:0] t);
`ifdef PC_ALIGN_CHECK_EN
        m_pc  = t - (t % FB);
        m_mis = ((t % FB) != 0);
`else
        m_pc  = t;
`endif
    endtask

    task automatic model_edge();
        m_mis = 1'b0;
        if (!rst) begin
            model_reset();
        end else if (!m_run) begin
            m_run = 1'b1;
        end else if (flush) begin
            model_load(new_pc);
            m_pv = 1'b0;
        end else if (stall[0]) begin
            if (branch_flag_i) begin
                m_pv   = 1'b1;
                m_pend = branch_target_address_i;
            end
        end else if (branch_flag_i) begin
            model_load(branch_target_address_i);
            m_pv = 1'b0;
        end else if (m_pv) begin
            model_load(m_pend);
            m_pv = 1'b0;
        end else begin
            m_pc = m_pc + FB;
        end
    endtask

    // Drive one cycle of inputs shortly after an edge, then clock the DUT and the model together.
    task automatic applyStimulus(input logic f, input logic [31:0] npc, input logic [5:0] st,
                                 input logic br, input logic [31:0] tgt);
        flush                   = f;
        new_pc                  = npc;
        stall                   = st;
        branch_flag_i           = br;
        branch_target_address_i = tgt;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] e_pc, input logic e_ce,
                               input logic e_pend, input logic e_mis);
        vectors++;
        if (pc !== e_pc || ce !== e_ce || redirect_pending_o !== e_pend || misalign_o !== e_mis) begin
            miscompares++;
            $display("[TB] FAIL %s: got pc=%h ce=%b pend=%b mis=%b, expected pc=%h ce=%b pend=%b mis=%b",
                     name, pc, ce, redirect_pending_o, misalign_o, e_pc, e_ce, e_pend, e_mis);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", RV, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("after_release", RV, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        stall = '0;
        flush = 1'b0;
        new_pc = '0;
        branch_flag_i = 1'b0;
        branch_target_address_i = '0;
        model_reset();

        // Directed vectors applied after the IDLE edge, starting with pc = 0x100 in RUN.
        tbl.push_back('{1'b0, 32'h0,        6'h00, 1'b0, 32'h0,    32'h104,      1'b0, 1'b0});
        tbl.push_back('{1'b0, 32'h0,        6'h00, 1'b0, 32'h0,    32'h108,      1'b0, 1'b0});
        tbl.push_back('{1'b0, 32'h0,        6'h01, 1'b0, 32'h0,    32'h108,      1'b0, 1'b0});
        tbl.push_back('{1'b0, 32'h0,        6'h01, 1'b1, 32'h2000, 32'h108,      1'b1, 1'b0});
        tbl.push_back('{1'b0, 32'h0,        6'h01, 1'b0, 32'h0,    32'h108,      1'b1, 1'b0});
        tbl.push_back('{1'b0, 32'h0,        6'h00, 1'b0, 32'h0,    32'h2000,     1'b0, 1'b0});
        tbl.push_back('{1'b0, 32'h0,        6'h00, 1'b0, 32'h0,    32'h2004,     1'b0, 1'b0});
        tbl.push_back('{1'b1, 32'h80,       6'h01, 1'b1, 32'h40,   32'h80,       1'b0, 1'b0});
        tbl.push_back('{1'b0, 32'h0,        6'h01, 1'b1, 32'h3000, 32'h80,       1'b1, 1'b0});
        tbl.push_back('{1'b0, 32'h0,        6'h01, 1'b1, 32'h3500, 32'h80,       1'b1, 1'b0});
        tbl.push_back('{1'b0, 32'h0,        6'h00, 1'b0, 32'h0,    32'h3500,     1'b0, 1'b0});
        tbl.push_back('{1'b0, 32'h0,        6'h01, 1'b1, 32'h3000, 32'h3500,     1'b1, 1'b0});
        tbl.push_back('{1'b0, 32'h0,        6'h00, 1'b1, 32'h4000, 32'h4000,     1'b0, 1'b0});
        tbl.push_back('{1'b0, 32'h0,        6'h00, 1'b0, 32'h0,    32'h4004,     1'b0, 1'b0});
        tbl.push_back('{1'b0, 32'h0,        6'h00, 1'b1, 32'h1006, EXP_1006,     1'b0, EXP_MIS});
        tbl.push_back('{1'b0, 32'h0,        6'h00, 1'b0, 32'h0,    EXP_NXT,      1'b0, 1'b0});
        tbl.push_back('{1'b1, 32'hFFFFFFFC, 6'h00, 1'b0, 32'h0,    32'hFFFFFFFC, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 32'h0,        6'h00, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0});
        tbl.push_back('{1'b0, 32'h0,        6'h3E, 1'b0, 32'h0,    32'h4,        1'b0, 1'b0});

        do_reset();
        // The IDLE edge ignores flush, stall and branch, and the first fetch is at the reset vector.
        applyStimulus(1'b1, 32'h80, 6'h01, 1'b1, 32'h40);
        checkOutput("idle_edge", RV, 1'b1, 1'b0, 1'b0);

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].f, tbl[i].npc, tbl[i].st, tbl[i].br, tbl[i].tgt);
            checkOutput($sformatf("vec%0d", i), tbl[i].exp_pc, 1'b1, tbl[i].exp_pend, tbl[i].exp_mis);
        end

        // Reset asserted mid-cycle while HELD must act at once and drop the pending target.
        applyStimulus(1'b0, 32'h0, 6'h01, 1'b1, 32'h5000);
        checkOutput("held_before_reset", 32'h4, 1'b1, 1'b1, 1'b0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        checkOutput("async_reset_in_held", RV, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h80, 6'h00, 1'b1, 32'h40);
        checkOutput("reset_held_across_edge", RV, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 6'h00, 1'b0, 32'h0);
        checkOutput("restart_idle_edge", RV, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 6'h00, 1'b0, 32'h0);
        checkOutput("no_stale_redirect", RV + 32'd4, 1'b1, 1'b0, 1'b0);

        // Random traffic checked against the model, including misaligned and wrapping targets.
        for (int i = 0; i < 600; i++) begin
            logic        f;
            logic        br;
            logic [5:0]  st;
            logic [31:0] npc;
            logic [31:0] tgt;
            f   = ($urandom_range(0, 15) == 0);
            br  = ($urandom_range(0, 3) == 0);
            st  = 6'($urandom);
            st[0] = ($urandom_range(0, 9) < 4);
            npc = ($urandom_range(0, 1) == 0) ? $urandom : (32'hFFFFFFF0 | 32'($urandom_range(0, 15)));
            tgt = $urandom;
            applyStimulus(f, npc, st, br, tgt);
            checkOutput($sformatf("rand%0d", i), m_pc, m_run, m_pv, m_mis);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_gen_mw.md
PC_GEN_MW -- requirements
Module: pc_gen_mw

Interface
REQ-001 Parameter ADDR_W, default 32, width of the PC and of all address ports.
REQ-002 Parameter RESET_VECTOR, default 0, first fetch address after reset.
REQ-003 Parameter FETCH_BYTES, default 4, sequential PC increment; power of two, 1 to 16.
REQ-004 Port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-006 Port stall  in  6  pipeline stall vector; only bit 0 (fetch stage) is used, 1 = hold.
REQ-007 Port flush  in  1  exception/flush redirect request.
REQ-008 Port new_pc  in  ADDR_W  flush target.
REQ-009 Port branch_flag_i  in  1  branch taken this cycle.
REQ-010 Port branch_target_address_i  in  ADDR_W  branch target.
REQ-011 Port pc  out  ADDR_W  current fetch address, registered.
REQ-012 Port ce  out  1  instruction-memory read enable, registered.
REQ-013 Port redirect_pending_o  out  1  a branch captured under stall is waiting.
REQ-014 Port misalign_o  out  1  one-cycle pulse, misaligned redirect target detected.

Function
REQ-015 The FSM SHALL have three states: IDLE (ce=0), RUN (ce=1, no pending), HELD (ce=1, pending branch valid).
REQ-016 IDLE -> RUN on the first rising edge after rst deasserts; pc SHALL hold RESET_VECTOR through this edge, so the first fetch is at RESET_VECTOR.
REQ-017 Priority at each edge in RUN/HELD SHALL be: flush > stall[0] > branch_flag_i > pending target > sequential.
REQ-018 flush=1 SHALL load pc<=new_pc regardless of stall, clear the pending register, and go to RUN.
REQ-019 With flush=0, stall[0]=1, branch_flag_i=1: pc holds, branch_target_address_i is captured into the pending register (newer capture overwrites older), state -> HELD.
REQ-020 With flush=0, stall[0]=1, branch_flag_i=0: pc and pending register SHALL hold.
REQ-021 With flush=0, stall[0]=0, branch_flag_i=1: pc<=branch_target_address_i, pending cleared, state -> RUN (a live branch beats a stale pending one).
REQ-022 With flush=0, stall[0]=0, branch_flag_i=0, in HELD: pc<=pending target, pending cleared, state -> RUN.
REQ-023 Otherwise in RUN: pc<=pc+FETCH_BYTES, modulo 2^ADDR_W (all-ones region wraps to 0, no flag).
REQ-024 redirect_pending_o SHALL equal 1 exactly when state is HELD.
REQ-025 In IDLE, flush, branch and stall inputs SHALL be ignored.

Reset
REQ-026 rst=0 SHALL immediately (without a clock) force ce=0, pc=RESET_VECTOR, pending cleared, misalign_o=0, state IDLE.
REQ-027 Reset asserted mid-operation, including in HELD, SHALL discard any pending target; no redirect survives reset.

Configuration
REQ-028 Macro PC_ALIGN_CHECK_EN SHALL control target alignment checking.
REQ-029 With PC_ALIGN_CHECK_EN defined: any target loaded into pc (flush, branch or pending) whose low log2(FETCH_BYTES) bits are nonzero SHALL be loaded with those bits cleared, and misalign_o SHALL pulse 1 in the cycle that pc shows the aligned value.
REQ-030 Without PC_ALIGN_CHECK_EN: targets SHALL be loaded unmodified and misalign_o SHALL be constant 0.

Verification
REQ-031 Reset release, no stall, ADDR_W=32, FETCH_BYTES=4, RESET_VECTOR=0x100 -> ce=0 with pc=0x100 until the first edge, then ce=1, then pc 0x100, 0x104, 0x108 on consecutive edges.
REQ-032 stall[0]=1 for 3 cycles with branch_flag_i=1, target 0x2000 in the 2nd cycle only -> pc held, redirect_pending_o=1 from the next edge; first unstalled edge gives pc=0x2000, then 0x2004.
REQ-033 Same cycle flush=1 new_pc=0x80, stall[0]=1, branch_flag_i=1 target 0x40 -> next pc=0x80, redirect_pending_o=0.
REQ-034 HELD with pending 0x3000, then stall[0]=0 with branch_flag_i=1 target 0x4000 -> pc=0x4000, pending cleared, 0x3000 never fetched.
REQ-035 pc=0xFFFFFFFC, no events -> next pc=0x00000000; rst pulsed low during HELD -> pc=RESET_VECTOR, ce=0, redirect_pending_o=0 immediately.
REQ-036 With PC_ALIGN_CHECK_EN, branch target 0x1006 -> pc=0x1004 with misalign_o=1 for one cycle; without the macro -> pc=0x1006, misalign_o=0.
